// File: rtl/flag_unit_pkg.sv
// flag_unit_pkg: shared miniRISC flag indices, FSM encodings and flag/branch opcodes
package flag_unit_pkg;
  localparam int FLAG_SIGN  = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_CARRY = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_t;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_SHL  = 6'h05;
  localparam logic [5:0] OP_MUL  = 6'h06;
  localparam logic [5:0] OP_BCY  = 6'h20;
  localparam logic [5:0] OP_BNCY = 6'h21;
  localparam logic [5:0] OP_BLTZ = 6'h22;
  localparam logic [5:0] OP_BZ   = 6'h23;
  localparam logic [5:0] OP_BNZ  = 6'h24;
endpackage

// File: rtl/flag_unit_eval.sv
// flag_eval: combinational sign/zero/carry evaluation of an ALU result
module flag_eval #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             new_sign,
  output logic             new_zero,
  output logic             new_carry
);
  assign new_sign  = alu_result[WIDTH-1];
  assign new_zero  = alu_result == '0;
  assign new_carry = alu_carry;
endmodule

// File: rtl/flag_unit.sv
// flag_unit: holds branch condition flags for one outstanding ALU op; FLAG_BYPASS_EN adds same-cycle bypass
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [2:0]       flag_mask,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             flush,
  output logic             sign,
  output logic             zero_flag,
  output logic             carry,
  output logic             flags_ready,
  output logic             issue_err
);
  state_t     state;
  logic [2:0] mask_q, flag_q, new_flags, use_mask, upd;
  logic       done_now;
  flag_eval #(.WIDTH(WIDTH)) u_eval (
    .alu_result(alu_result),
    .alu_carry (alu_carry),
    .new_sign  (new_flags[FLAG_SIGN]),
    .new_zero  (new_flags[FLAG_ZERO]),
    .new_carry (new_flags[FLAG_CARRY])
  );
  // a completion is either a pending op finishing or a single-cycle op issued in IDLE
  assign done_now = !flush && alu_done && (state == ST_PENDING || issue);
  assign use_mask = state == ST_PENDING ? mask_q : flag_mask;
  assign upd      = (flag_q & ~use_mask) | (new_flags & use_mask);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mask_q    <= 3'b000;
      flag_q    <= 3'b000;
      issue_err <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      if (done_now) flag_q <= upd;
      if (issue && (state == ST_IDLE ? !alu_done : alu_done)) mask_q <= flag_mask;
      if (state == ST_IDLE && issue && !alu_done) state <= ST_PENDING;
      if (state == ST_PENDING && alu_done && !issue) state <= ST_IDLE;
      if (state == ST_PENDING && issue && !alu_done) issue_err <= 1'b1;
    end
  end
`ifdef FLAG_BYPASS_EN
  assign {carry, zero_flag, sign} = done_now ? upd : flag_q;
  assign flags_ready = state == ST_IDLE || done_now;
`else
  assign {carry, zero_flag, sign} = flag_q;
  assign flags_ready = state == ST_IDLE;
`endif
endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: scoreboard bench for flag_unit, expected flag vectors queued per driven cycle
module tb_flag_unit;
  logic        clk = 1'b0;
  logic        rst_n, issue, alu_done, alu_carry, flush;
  logic [2:0]  flag_mask;
  logic [31:0] alu_result;
  logic        sign, zero_flag, carry, flags_ready, issue_err;
  int          n_cmp = 0, n_bad = 0;
  logic [4:0]  exp_q[$];
  typedef struct packed {
    logic        rst_n, issue;
    logic [2:0]  mask;
    logic        done;
    logic [31:0] res;
    logic        cy, fl;
    logic [4:0]  exp;
  } row_t;

  flag_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .flag_mask(flag_mask),
    .alu_done(alu_done), .alu_result(alu_result), .alu_carry(alu_carry),
    .flush(flush), .sign(sign), .zero_flag(zero_flag), .carry(carry),
    .flags_ready(flags_ready), .issue_err(issue_err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {sign, zero_flag, carry, flags_ready, issue_err};
  endfunction

  task automatic drive(input row_t r);
    rst_n = r.rst_n; issue = r.issue; flag_mask = r.mask; alu_done = r.done;
    alu_result = r.res; alu_carry = r.cy; flush = r.fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[3] = '{
      '{1'b0, 1'b1, 3'b111, 1'b1, 32'h0, 1'b1, 1'b0, 5'b00010},
      '{1'b0, 1'b1, 3'b111, 1'b1, 32'h0, 1'b1, 1'b0, 5'b00010},
      '{1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0, 5'b00010}};
    logic [4:0] want;
    foreach (rows[i]) begin
      drive(rows[i]); exp_q.push_back(rows[i].exp); tick(); want = exp_q.pop_front(); n_cmp++;
      if (obs() !== want) begin n_bad++; $display("FAIL reset[%0d]: got s,z,c,rdy,err=%b want %b", i, obs(), want); end
    end
  endtask

  task automatic test_single_cycle();
    row_t rows[2] = '{
      '{1'b1, 1'b1, 3'b111, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 5'b10110},
      '{1'b1, 1'b0, 3'b000, 1'b0, 32'h0,         1'b0, 1'b0, 5'b10110}};
    logic [4:0] want;
    foreach (rows[i]) begin
      drive(rows[i]); exp_q.push_back(rows[i].exp); tick(); want = exp_q.pop_front(); n_cmp++;
      if (obs() !== want) begin n_bad++; $display("FAIL single[%0d]: got s,z,c,rdy,err=%b want %b", i, obs(), want); end
    end
  endtask

  task automatic test_multi_cycle();
    row_t rows[5] = '{
      '{1'b1, 1'b1, 3'b010, 1'b0, 32'h0, 1'b0, 1'b0, 5'b10100},
      '{1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0, 5'b10100},
      '{1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0, 5'b10100},
      '{1'b1, 1'b0, 3'b000, 1'b1, 32'h0, 1'b0, 1'b0, 5'b11110},
      '{1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0, 5'b11110}};
    logic [4:0] want;
    foreach (rows[i]) begin
      drive(rows[i]); exp_q.push_back(rows[i].exp); tick(); want = exp_q.pop_front(); n_cmp++;
      if (obs() !== want) begin n_bad++; $display("FAIL multi[%0d]: got s,z,c,rdy,err=%b want %b", i, obs(), want); end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[3] = '{
      '{1'b1, 1'b1, 3'b111, 1'b0, 32'h0,         1'b0, 1'b0, 5'b11100},
      '{1'b1, 1'b1, 3'b001, 1'b1, 32'h1,         1'b0, 1'b0, 5'b00000},
      '{1'b1, 1'b0, 3'b000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'b10010}};
    logic [4:0] want;
    foreach (rows[i]) begin
      drive(rows[i]); exp_q.push_back(rows[i].exp); tick(); want = exp_q.pop_front(); n_cmp++;
      if (obs() !== want) begin n_bad++; $display("FAIL b2b[%0d]: got s,z,c,rdy,err=%b want %b", i, obs(), want); end
    end
  endtask

  task automatic test_err_flush();
    row_t rows[8] = '{
      '{1'b1, 1'b1, 3'b111, 1'b0, 32'h0, 1'b0, 1'b0, 5'b10000},
      '{1'b1, 1'b1, 3'b010, 1'b0, 32'h0, 1'b0, 1'b0, 5'b10001},
      '{1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0, 5'b10001},
      '{1'b1, 1'b0, 3'b000, 1'b1, 32'h0, 1'b1, 1'b1, 5'b10011},
      '{1'b1, 1'b1, 3'b111, 1'b1, 32'h0, 1'b1, 1'b1, 5'b10011},
      '{1'b1, 1'b0, 3'b000, 1'b1, 32'h0, 1'b1, 1'b0, 5'b10011},
      '{1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0, 5'b10011},
      '{1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0, 5'b00010}};
    logic [4:0] want;
    foreach (rows[i]) begin
      drive(rows[i]); exp_q.push_back(rows[i].exp); tick(); want = exp_q.pop_front(); n_cmp++;
      if (obs() !== want) begin n_bad++; $display("FAIL err_flush[%0d]: got s,z,c,rdy,err=%b want %b", i, obs(), want); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    drive('{1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0, 5'b00000});
    test_reset();
    test_single_cycle();
    test_multi_cycle();
    test_back_to_back();
    test_err_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
